// File: rtl/addsub_cs_pipe.sv
// Multi-limb carry-select adder/subtractor: one shared limb-adder bank evaluated with
// carry-in 0 then 1, followed by carry resolution over SEL_PER_CYCLE limbs per cycle.
module addsub_cs_pipe #(
   parameter int W_LIMB        = 256,
   parameter int N_LIMB        = 13,
   parameter int SEL_PER_CYCLE = 13,
   localparam int WIDTH        = W_LIMB * N_LIMB
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             sub_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] c_o,
   output logic             c_out_o
);

   // state | meaning
   // IDLE  | waiting for operands, in_ready high
   // GEN0  | limb sums with carry-in 0 (limb 0 takes cin0)
   // GEN1  | limb sums with carry-in 1
   // SEL   | resolve carry chain one group of limbs per cycle
   // DONE  | result valid, held until out_ready
   localparam int N_SEL = (N_LIMB + SEL_PER_CYCLE - 1) / SEL_PER_CYCLE;
   localparam int GW    = (N_SEL > 1) ? $clog2(N_SEL) : 1;

   typedef enum logic [2:0] {S_IDLE, S_GEN0, S_GEN1, S_SEL, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  bx_q, bx_d;
   logic              cin0_q, cin0_d;
   logic [W_LIMB:0]   s0_q [N_LIMB];
   logic [W_LIMB:0]   s0_d [N_LIMB];
   logic [W_LIMB:0]   s1_q [N_LIMB];
   logic [W_LIMB:0]   s1_d [N_LIMB];
   logic [GW-1:0]     grp_q, grp_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  c_q, c_d;
   logic              c_out_q, c_out_d;
   logic              out_valid_q, out_valid_d;

   logic              accept;
   logic [W_LIMB:0]   sum_w [N_LIMB];
   logic [W_LIMB:0]   limb_w;
   logic              carry_v;
   logic              cin_l;

   assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
   assign accept      = in_valid_i && in_ready_o;
   assign out_valid_o = out_valid_q;
   assign c_o         = c_q;
   assign c_out_o     = c_out_q;

   // The same adder bank serves GEN0 and GEN1; only the limb carry-in differs.
   always_comb begin
      for (int i = 0; i < N_LIMB; i++) begin
         cin_l = (state_q == S_GEN1) ? 1'b1 : ((i == 0) ? cin0_q : 1'b0);
         sum_w[i] = {1'b0, a_q[i*W_LIMB +: W_LIMB]} + {1'b0, bx_q[i*W_LIMB +: W_LIMB]}
                  + {{W_LIMB{1'b0}}, cin_l};
      end
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      bx_d        = bx_q;
      cin0_d      = cin0_q;
      s0_d        = s0_q;
      s1_d        = s1_q;
      grp_d       = grp_q;
      carry_d     = carry_q;
      c_d         = c_q;
      c_out_d     = c_out_q;
      out_valid_d = out_valid_q;
      limb_w      = '0;
      carry_v     = carry_q;

      if (accept) begin
         a_d    = a_i;
         bx_d   = sub_i ? ~b_i : b_i;
         cin0_d = sub_i;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_GEN0;
         end
         S_GEN0: begin
            s0_d    = sum_w;
            state_d = S_GEN1;
         end
         S_GEN1: begin
            s1_d    = sum_w;
            grp_d   = '0;
            carry_d = 1'b0;
            state_d = S_SEL;
         end
         S_SEL: begin
            // carry_q is 0 entering group 0, so limb 0 always takes s0[0]
            for (int i = 0; i < N_LIMB; i++) begin
               if ((i / SEL_PER_CYCLE) == int'(grp_q)) begin
                  limb_w = carry_v ? s1_q[i] : s0_q[i];
                  c_d[i*W_LIMB +: W_LIMB] = limb_w[W_LIMB-1:0];
                  carry_v = limb_w[W_LIMB];
               end
            end
            carry_d = carry_v;
            if (int'(grp_q) == N_SEL - 1) begin
               c_out_d     = carry_v;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               grp_d = grp_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready_i) begin
               out_valid_d = 1'b0;
               state_d     = accept ? S_GEN0 : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         bx_q        <= '0;
         cin0_q      <= 1'b0;
         grp_q       <= '0;
         carry_q     <= 1'b0;
         c_q         <= '0;
         c_out_q     <= 1'b0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < N_LIMB; i++) begin
            s0_q[i] <= '0;
            s1_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         bx_q        <= bx_d;
         cin0_q      <= cin0_d;
         grp_q       <= grp_d;
         carry_q     <= carry_d;
         c_q         <= c_d;
         c_out_q     <= c_out_d;
         out_valid_q <= out_valid_d;
         for (int i = 0; i < N_LIMB; i++) begin
            s0_q[i] <= s0_d[i];
            s1_q[i] <= s1_d[i];
         end
      end
   end

endmodule

// File: tb/tb_addsub_cs_pipe.sv
// Directed bench for addsub_cs_pipe in an 8-bit x 4-limb, two-limbs-per-SEL configuration.
module tb_addsub_cs_pipe;
   localparam int W_LIMB = 8;
   localparam int N_LIMB = 4;
   localparam int SPC    = 2;
   localparam int WIDTH  = W_LIMB * N_LIMB;
   localparam int LAT    = 2 + (N_LIMB + SPC - 1) / SPC;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] c;
   logic             c_out;

   int checks = 0;
   int errors = 0;

   addsub_cs_pipe #(.W_LIMB(W_LIMB), .N_LIMB(N_LIMB), .SEL_PER_CYCLE(SPC)) dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .sub_i(sub), .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .c_o(c), .c_out_o(c_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called 1ns after a rising edge; returns 1ns after the accept edge.
   task automatic start_op(input logic s, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input string tag);
      sub = s; a = av; b = bv; in_valid = 1'b1;
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom; sub = ~s;
      chk({tag, "_busy"}, 64'(in_ready), 64'd0);
   endtask

   task automatic wait_result(input logic [WIDTH-1:0] exp_c, input logic exp_co, input string tag);
      int k;
      k = 0;
      while (!out_valid && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      chk({tag, "_latency"}, 64'(k), 64'(LAT));
      chk({tag, "_c"}, 64'(c), 64'(exp_c));
      chk({tag, "_c_out"}, 64'(c_out), 64'(exp_co));
   endtask

   task automatic run_op(input logic s, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic [WIDTH-1:0] exp_c, input logic exp_co, input string tag);
      start_op(s, av, bv, tag);
      wait_result(exp_c, exp_co, tag);
      @(posedge clk); #1;
      chk({tag, "_drop"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; sub = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_c", 64'(c), 64'd0);
      chk("rst_c_out", 64'(c_out), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, "add_wrap");
      run_op(1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, "sub_borrow");
      run_op(1'b1, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, "sub_pos");
      run_op(1'b1, 32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 1'b1, "sub_eq");
      run_op(1'b0, 32'h1234_5678, 32'h0FED_CBA9, 32'h2222_2221, 1'b0, "add_mix");
      run_op(1'b0, 32'h80FF_00FF, 32'h8001_0001, 32'h0100_0100, 1'b1, "add_cout");

      // backpressure: result held, then a new accept on the releasing edge
      out_ready = 1'b0;
      start_op(1'b0, 32'h0000_0003, 32'h0000_0004, "bp");
      wait_result(32'h0000_0007, 1'b0, "bp");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", 64'(out_valid), 64'd1);
         chk("bp_hold_c", {31'd0, c_out, c}, 64'h0000_0000_0000_0007);
         chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
      end
      sub = 1'b1; a = 32'h0000_0100; b = 32'h0000_0001; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom; sub = 1'b0;
      chk("bp_release_drop", 64'(out_valid), 64'd0);
      wait_result(32'h0000_00FF, 1'b1, "bp_next");
      @(posedge clk); #1;

      // reset during the second SEL cycle
      start_op(1'b0, 32'h1111_1111, 32'h2222_2222, "abort");
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("abort_pre_c", 64'(c[15:0]), 64'h3333);
      rst = 1'b1;
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_c", 64'(c), 64'd0);
      chk("abort_c_out", 64'(c_out), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      run_op(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end
endmodule
